// File: rtl/btb_predictor_pkg.sv
// Shared widths, direction-counter encodings and PC field helpers for the
// branch target buffer.
package btb_predictor_pkg;

    localparam int PC_W    = 16;
    localparam int IDX_W   = 4;
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_WNT;
        endcase
        return nxt;
    endfunction

    function automatic logic [IDX_W-1:0] pc_idx(input logic [PC_W-1:0] pc);
        return pc[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_W-1:0] pc);
        return pc[PC_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/btb_predictor_perf_cnt.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module btb_perf_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count qualifying events, holding once the counter is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {W{1'b0}};
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup on the
// fetch PC, registered learning from EX resolution, plus hit/mispredict stats.
module btb_predictor
    import btb_predictor_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] i_lookup_pc,
    input  logic            i_lookup_vld,
    output logic            o_btb_hit,
    output logic [PC_W-1:0] o_btb_nxt_pc,
    input  logic            i_upd_en,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [PC_W-1:0] i_upd_target,
    input  logic            i_upd_mispred,
    input  logic            i_inv_all,
    output logic [CNT_W-1:0] o_stat_hits,
    output logic [CNT_W-1:0] o_stat_mispred
);

    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [PC_W-1:0]    r_target [ENTRIES];

    logic [IDX_W-1:0]   w_lk_idx;
    logic               w_lk_hit;
    logic [IDX_W-1:0]   w_up_idx;
    logic               w_up_match;

    assign w_lk_idx   = pc_idx(i_lookup_pc);
    assign w_up_idx   = pc_idx(i_upd_pc);
    assign w_up_match = r_valid[w_up_idx] && (r_tag[w_up_idx] == pc_tag(i_upd_pc));

    // Lookup sees only pre-update contents; a miss drives a zero target.
    always_comb begin
        w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == pc_tag(i_lookup_pc))
                   && r_ctr[w_lk_idx][1];
        if (w_lk_hit) begin
            o_btb_nxt_pc = r_target[w_lk_idx];
        end else begin
            o_btb_nxt_pc = {PC_W{1'b0}};
        end
    end

    assign o_btb_hit = w_lk_hit;

    // Valid bits and counters; invalidation takes priority over a same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_WNT;
        end else if (i_inv_all) begin
            r_valid <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_WNT;
        end else if (i_upd_en) begin
            if (w_up_match) begin
                r_ctr[w_up_idx] <= sat_ctr_next(r_ctr[w_up_idx], i_upd_taken);
            end else if (i_upd_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= CTR_WT;
            end else begin
                r_ctr[w_up_idx] <= r_ctr[w_up_idx];
            end
        end else begin
            r_valid <= r_valid;
        end
    end

    // Tag/target payload is left unreset; the valid bit alone qualifies it.
    always_ff @(posedge clk) begin
        if (i_upd_en && !i_inv_all && i_upd_taken) begin
            r_target[w_up_idx] <= i_upd_target;
            if (!w_up_match) begin
                r_tag[w_up_idx] <= pc_tag(i_upd_pc);
            end else begin
                r_tag[w_up_idx] <= r_tag[w_up_idx];
            end
        end else begin
            r_target[w_up_idx] <= r_target[w_up_idx];
        end
    end

    btb_perf_cnt #(.W(CNT_W)) u_hits_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (i_lookup_vld && w_lk_hit),
        .o_cnt (o_stat_hits)
    );

    btb_perf_cnt #(.W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (i_upd_en && i_upd_mispred),
        .o_cnt (o_stat_mispred)
    );

endmodule
